// File: rtl/riscv_pkg.sv
// Core-wide constants and types shared by the decode/execute datapath,
// including the default geometry of the integer register file.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_DEPTH = 32;
  localparam int REG_AW    = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_reg_cell.sv
// One WIDTH-bit storage word with per-byte write strobes and asynchronous clear.
module reg_cell #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH/8-1:0] strb,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;

  // Only strobed bytes take the new data; the rest hold their old value.
  always_comb begin
    word_d = word_q;
    if (en) begin
      for (int i = 0; i < NB; i++) begin
        if (strb[i]) begin
          word_d[8*i +: 8] = d[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/register_file.sv
// Integer register file: DEPTH byte-strobed words, one write port and NRD
// combinational read ports with optional hardwired zero entry and write bypass.
module register_file
  import riscv_pkg::*;
#(
  parameter  int WIDTH    = XLEN,
  parameter  int DEPTH    = REG_DEPTH,
  parameter  int NRD      = 2,
  parameter  bit ZERO_REG = 1'b1,
  parameter  bit BYPASS   = 1'b1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   wstrb,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic                 wr_ack
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] cellQ [DEPTH];
  logic [DEPTH-1:0] cellEn;
  logic             wrAck_q;

  // Entry 0 is never enabled when it is the hardwired zero register.
  for (genvar j = 0; j < DEPTH; j++) begin : g_cell
    assign cellEn[j] = we && (waddr == AW'(j)) && !(ZERO_REG && (j == 0));

    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (cellEn[j]),
      .strb (wstrb),
      .d    (wdata),
      .q    (cellQ[j])
    );
  end

  // Zero-register override wins over bypass, which wins over stored data.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    rdAddr;
    logic [WIDTH-1:0] rdWord;

    assign rdAddr = raddr[k*AW +: AW];

    always_comb begin
      rdWord = cellQ[rdAddr];
      if (BYPASS && we && !rst && (rdAddr == waddr)) begin
        for (int i = 0; i < NB; i++) begin
          if (wstrb[i]) begin
            rdWord[8*i +: 8] = wdata[8*i +: 8];
          end
        end
      end
      if (ZERO_REG && (rdAddr == '0)) begin
        rdWord = '0;
      end
    end

    assign rdata[k*WIDTH +: WIDTH] = rdWord;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrAck_q <= 1'b0;
    end else begin
      wrAck_q <= we;
    end
  end

  assign wr_ack = wrAck_q;

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: a default instance (zero register + bypass) and a
// plain instance (no zero register, no bypass) driven in lockstep against a reference model.
module tb_register_file;

  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        we;
  reg_addr_t   waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  reg_addr_t   raddr0;
  reg_addr_t   raddr1;
  logic [9:0]  raddr;
  logic [63:0] rdataA;
  logic [63:0] rdataB;
  logic        wrAckA;
  logic        wrAckB;

  logic [31:0] memA [32];
  logic [31:0] memB [32];
  logic        ackExp;

  int vectors;
  int miscompares;

  assign raddr = {raddr1, raddr0};

  register_file dutA (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .raddr  (raddr),
    .rdata  (rdataA),
    .wr_ack (wrAckA)
  );

  register_file #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dutB (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .raddr  (raddr),
    .rdata  (rdataB),
    .wr_ack (wrAckB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mergeWord(input logic [31:0] oldW, input logic [31:0] newW,
                                            input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (oldW & ~mask) | (newW & mask);
  endfunction

  // Expected read value from the architectural rules, not from the RTL structure.
  function automatic logic [31:0] expRead(input bit isA, input reg_addr_t a);
    logic [31:0] stored;
    stored = isA ? memA[a] : memB[a];
    if (isA && a == 5'd0) return 32'h0;
    if (isA && we && !rst && a == waddr) return mergeWord(stored, wdata, wstrb);
    return stored;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) begin
      memA[i] = 32'h0;
      memB[i] = 32'h0;
    end
    ackExp = 1'b0;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_A0"}, rdataA[31:0],  expRead(1'b1, raddr0));
    checkVal({tag, "_A1"}, rdataA[63:32], expRead(1'b1, raddr1));
    checkVal({tag, "_B0"}, rdataB[31:0],  expRead(1'b0, raddr0));
    checkVal({tag, "_B1"}, rdataB[63:32], expRead(1'b0, raddr1));
  endtask

  task automatic checkAck(input string tag);
    checkVal({tag, "_ackA"}, {31'h0, wrAckA}, {31'h0, ackExp});
    checkVal({tag, "_ackB"}, {31'h0, wrAckB}, {31'h0, ackExp});
  endtask

  task automatic applyStimulus(input logic w, input reg_addr_t wa, input logic [31:0] wd,
                               input logic [3:0] ws, input reg_addr_t r0, input reg_addr_t r1);
    @(negedge clk);
    we     = w;
    waddr  = wa;
    wdata  = wd;
    wstrb  = ws;
    raddr0 = r0;
    raddr1 = r1;
    #1;
  endtask

  // Advance the model across one rising edge, then let outputs settle.
  task automatic clockEdge();
    @(posedge clk);
    if (rst) begin
      ackExp = 1'b0;
    end else begin
      if (we) begin
        if (waddr != 5'd0) memA[waddr] = mergeWord(memA[waddr], wdata, wstrb);
        memB[waddr] = mergeWord(memB[waddr], wdata, wstrb);
      end
      ackExp = we;
    end
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    wstrb  = '0;
    raddr0 = '0;
    raddr1 = '0;
    clearModel();

    #15;
    @(negedge clk);
    checkOutput("reset");
    checkAck("reset");
    rst = 1'b0;

    // Write, then reassert reset mid-cycle while another write is pending.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd5);
    clockEdge();
    checkOutput("t1_wr");
    checkAck("t1_wr");
    checkVal("t1_const", rdataB[31:0], 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd5, 32'h12345678, 4'hF, 5'd5, 5'd6);
    rst = 1'b1;
    clearModel();
    #1;
    checkOutput("t1_rst");
    checkAck("t1_rst");
    checkVal("t1_rst_const", rdataA[31:0], 32'h0);
    clockEdge();
    checkOutput("t1_rst_edge");
    checkAck("t1_rst_edge");
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;

    // Byte-strobed partial overwrite.
    applyStimulus(1'b1, 5'd7, 32'h11223344, 4'hF, 5'd7, 5'd7);
    clockEdge();
    checkAck("t2_w1");
    applyStimulus(1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 5'd7, 5'd7);
    checkOutput("t2_pre");
    clockEdge();
    checkOutput("t2_post");
    checkAck("t2_w2");
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7);
    clockEdge();
    checkAck("t2_idle");
    checkVal("t2_constA", rdataA[31:0], 32'h11BB33DD);
    checkVal("t2_constB", rdataB[63:32], 32'h11BB33DD);

    // Entry 0 write: ignored by the zero-register instance only.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0);
    checkOutput("t3_pre");
    clockEdge();
    checkOutput("t3_post");
    checkAck("t3");
    checkVal("t3_constA", rdataA[31:0], 32'h0);
    checkVal("t3_constB", rdataB[31:0], 32'hFFFFFFFF);

    // Same-cycle forwarding on both ports.
    applyStimulus(1'b1, 5'd3, 32'h00000042, 4'hF, 5'd3, 5'd3);
    checkOutput("t4_pre");
    checkVal("t4_bypA0", rdataA[31:0],  32'h42);
    checkVal("t4_bypA1", rdataA[63:32], 32'h42);
    checkVal("t4_oldB",  rdataB[31:0],  32'h0);
    clockEdge();
    checkOutput("t4_post");
    checkVal("t4_newB", rdataB[63:32], 32'h42);

    // Walking write then full sweep.
    for (int j = 0; j < 32; j++) begin
      applyStimulus(1'b1, 5'(j), 32'(j * 3), 4'hF, 5'(j), 5'(31 - j));
      checkOutput("t5_wr");
      clockEdge();
    end
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'(a), 5'(31 - a));
      checkOutput("t5_sweep");
    end

    // Empty strobe write and idle cycles with toggling data.
    applyStimulus(1'b1, 5'd9, 32'h5A5A5A5A, 4'hF, 5'd9, 5'd9);
    clockEdge();
    applyStimulus(1'b1, 5'd9, 32'h0F0F1234, 4'h0, 5'd9, 5'd9);
    checkOutput("t6_pre");
    clockEdge();
    checkOutput("t6_post");
    checkAck("t6");
    checkVal("t6_const", rdataA[31:0], 32'h5A5A5A5A);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 5'(c + 8), (c % 2 == 0) ? 32'hFFFFFFFF : 32'h0, 4'hF, 5'd9, 5'(c + 8));
      clockEdge();
      checkOutput("t6_idle");
      checkAck("t6_idle");
    end

    // Randomised traffic with biased read/write address collisions.
    for (int n = 0; n < 300; n++) begin
      reg_addr_t wa;
      reg_addr_t r0;
      reg_addr_t r1;
      wa = 5'($urandom_range(0, 31));
      r0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)), r0, r1);
      checkOutput("rnd_pre");
      clockEdge();
      checkOutput("rnd_post");
      checkAck("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
